hack_boot_loader: RTL
=====================

Name: hack_boot_loader

Overview:
- Instruction-side companion to the Hack cpu.
- Receives a program image as a byte stream over a valid/ready handshake and writes it into internal instruction ROM.
- Holds the cpu in reset until a complete, checksum-verified image is loaded, then serves instruction = ROM[PCout] combinationally each cycle.

Parameters:
- ADDR_W, 12, ROM address width; DEPTH = 2**ADDR_W words of 16 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming image byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte on this cycle.
- load_req  input  1  request reload; sampled in RUN/ERR only.
- PCout  input  16  program counter from cpu.
- instruction  output  16  instruction word to cpu.
- cpu_rst  output  1  active-high reset to cpu, registered.
- loading  output  1  high in any load state.
- error  output  1  high in ERR.
- word_count  output  ADDR_W+1  declared image length N.

Behaviour:
- Byte accept: rx_valid & rx_ready at a rising clk edge. No accept means no state change; gaps in rx_valid are legal.
- Image format: LEN_HI, LEN_LO (N, big-endian), then N words with high byte first, then one check byte.
- Check byte must equal the XOR of every preceding image byte, including the length bytes.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, ERR.
- LEN_HI: accept → store high length byte → LEN_LO.
- LEN_LO: accept → N formed.
  - N > DEPTH → ERR.
  - N = 0 → CHECK.
  - Otherwise → DATA_HI with wr_addr = 0.
- DATA_HI: accept → latch byte → DATA_LO.
- DATA_LO: accept → ROM[wr_addr] <= {hi, byte}; wr_addr++.
  - If wr_addr+1 == N → CHECK, else → DATA_HI.
- CHECK: accept → compare byte against running XOR.
  - Match → RUN.
  - Mismatch → ERR.
- RUN / ERR: load_req high → LEN_HI. Running XOR, wr_addr and word_count clear on that transition.
- rx_ready = 1 in LEN_HI..CHECK, 0 in RUN/ERR (decoded from state).
- loading = 1 in LEN_HI..CHECK. error = 1 only in ERR.
- cpu_rst is registered as (next_state != RUN):
  - Goes 0 on the edge that accepts a matching check byte.
  - Goes 1 on the edge that takes load_req.
- instruction is combinational.
  - In RUN: ROM[PCout[ADDR_W-1:0]] when PCout < N, else 16'h0000.
  - Outside RUN: 16'h0000.
- word_count updates on the LEN_LO accept; cleared to 0 on reload entry.
- Reset values (rst low, immediate, asynchronous):
  - state LEN_HI, cpu_rst 1, rx_ready 1, loading 1, error 0.
  - word_count 0, wr_addr 0, XOR 0, instruction 0.
- ROM contents are not cleared by reset or reload. Stale words are unreachable because N = 0 until a new load completes.
- Reset mid-load discards the partial image; the next byte accepted is treated as LEN_HI.
- load_req is ignored in load states. rx_valid is ignored in RUN/ERR.
- N = DEPTH is legal and fills ROM exactly.

Test Plan:
- Nominal load:
  - Release rst, send bytes 00 02 00 0F EC 10 F1.
  - cpu_rst falls on the F1 accept edge; word_count = 2.
  - PCout = 0 → 000F, PCout = 1 → EC10, PCout = 2 → 0000.
  - rx_ready = 0 afterwards.
- Bad checksum:
  - Send the same image with check byte F0.
  - error = 1, cpu_rst stays 1, rx_ready = 0, instruction = 0000.
  - Then load_req = 1 plus the valid image → RUN.
- Oversize length (ADDR_W = 12):
  - Send 10 01.
  - ERR on the second-byte edge; no ROM write occurs.
- Handshake stalls:
  - Nominal image with rx_valid low for 0–3 random cycles between bytes.
  - Identical end state and ROM contents to the nominal load.
- Async reset mid-data:
  - After 00 02 00, pull rst low between clock edges.
  - Outputs take reset values before the next edge.
  - Then 00 00 00 → RUN with N = 0; every PCout gives 0000.
- Reload from RUN:
  - After the nominal load, pulse load_req.
  - cpu_rst = 1 next edge, word_count = 0.
  - Load 00 01 12 34 27 → PCout = 0 gives 1234, PCout = 1 gives 0000.

Source files
------------

// File: rtl/hack_boot_loader.sv
// Boot loader for the Hack cpu: receives a length-prefixed, XOR-checked program image
// over a byte handshake, fills the instruction ROM and releases the cpu once it checks out.
module hack_boot_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    input  logic [15:0]       PCout,
    output logic [15:0]       instruction,
    output logic              cpu_rst,
    output logic              loading,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [16:0]     DEPTH_C = 17'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W + 1){1'b0}};

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_CHECK   = 3'd4,
        S_RUN     = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic [7:0]      len_hi_r;
    logic [7:0]      data_hi_r;
    logic [7:0]      xor_r;
    logic [ADDR_W:0] wr_addr_r;
    logic [ADDR_W:0] word_count_r;
    logic            cpu_rst_r;
    logic            rx_ready_r;
    logic            loading_r;
    logic            error_r;
    logic            accept_s;
    logic            wr_en_s;
    logic [15:0]     len_s;
    logic [15:0]     wc_ext_s;
    logic [15:0]     rom_r [DEPTH];

    // Running image checksum: plain XOR of every byte seen so far.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign accept_s = rx_valid & rx_ready_r;
    assign len_s    = {len_hi_r, rx_data};
    assign wc_ext_s = {{(15 - ADDR_W){1'b0}}, word_count_r};

    // Next-state decode of the load sequence.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_LEN_HI: begin
                if (accept_s) next_s = S_LEN_LO;
                else          next_s = state_r;
            end
            S_LEN_LO: begin
                if (!accept_s)                     next_s = state_r;
                else if ({1'b0, len_s} > DEPTH_C)  next_s = S_ERR;
                else if (len_s == 16'h0000)        next_s = S_CHECK;
                else                               next_s = S_DATA_HI;
            end
            S_DATA_HI: begin
                if (accept_s) next_s = S_DATA_LO;
                else          next_s = state_r;
            end
            S_DATA_LO: begin
                if (!accept_s)                              next_s = state_r;
                else if (wr_addr_r + ONE_C == word_count_r) next_s = S_CHECK;
                else                                        next_s = S_DATA_HI;
            end
            S_CHECK: begin
                if (!accept_s)             next_s = state_r;
                else if (rx_data == xor_r) next_s = S_RUN;
                else                       next_s = S_ERR;
            end
            S_RUN, S_ERR: begin
                if (load_req) next_s = S_LEN_HI;
                else          next_s = state_r;
            end
            default: next_s = S_LEN_HI;
        endcase
    end

    // State, datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_LEN_HI;
            len_hi_r     <= 8'h00;
            data_hi_r    <= 8'h00;
            xor_r        <= 8'h00;
            wr_addr_r    <= ZERO_C;
            word_count_r <= ZERO_C;
            cpu_rst_r    <= 1'b1;
            rx_ready_r   <= 1'b1;
            loading_r    <= 1'b1;
            error_r      <= 1'b0;
        end else begin
            state_r    <= next_s;
            cpu_rst_r  <= (next_s != S_RUN);
            rx_ready_r <= (next_s != S_RUN) && (next_s != S_ERR);
            loading_r  <= (next_s != S_RUN) && (next_s != S_ERR);
            error_r    <= (next_s == S_ERR);
            case (state_r)
                S_LEN_HI: begin
                    if (accept_s) begin
                        len_hi_r <= rx_data;
                        xor_r    <= csum_update(xor_r, rx_data);
                    end
                end
                S_LEN_LO: begin
                    if (accept_s) begin
                        word_count_r <= len_s[ADDR_W:0];
                        wr_addr_r    <= ZERO_C;
                        xor_r        <= csum_update(xor_r, rx_data);
                    end
                end
                S_DATA_HI: begin
                    if (accept_s) begin
                        data_hi_r <= rx_data;
                        xor_r     <= csum_update(xor_r, rx_data);
                    end
                end
                S_DATA_LO: begin
                    if (accept_s) begin
                        wr_addr_r <= wr_addr_r + ONE_C;
                        xor_r     <= csum_update(xor_r, rx_data);
                    end
                end
                S_RUN, S_ERR: begin
                    if (load_req) begin
                        xor_r        <= 8'h00;
                        wr_addr_r    <= ZERO_C;
                        word_count_r <= ZERO_C;
                    end
                end
                default: begin
                    xor_r <= xor_r;
                end
            endcase
        end
    end

    // ROM write strobe: low byte of a word completes it.
    always_comb begin
        wr_en_s = 1'b0;
        if (accept_s && (state_r == S_DATA_LO)) wr_en_s = 1'b1;
        else                                    wr_en_s = 1'b0;
    end

    // Instruction ROM; contents deliberately survive reset, word_count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s) rom_r[wr_addr_r[ADDR_W-1:0]] <= {data_hi_r, rx_data};
    end

    // Fetch path: only words inside the loaded image are visible, and only in RUN.
    always_comb begin
        instruction = 16'h0000;
        if ((state_r == S_RUN) && (PCout < wc_ext_s)) instruction = rom_r[PCout[ADDR_W-1:0]];
        else                                          instruction = 16'h0000;
    end

    assign cpu_rst    = cpu_rst_r;
    assign rx_ready   = rx_ready_r;
    assign loading    = loading_r;
    assign error      = error_r;
    assign word_count = word_count_r;

endmodule
